// File: rtl/input_conditioner.sv
// Board-input front end: synchronises the raw active-low keys and switch bank,
// debounces both keys into active-high levels with press pulses, and holds the switches on ClearA_LoadB.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SW_W            = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Run_n,
  input  logic            ClearA_LoadB_n,
  input  logic [SW_W-1:0] SW,
  output logic            Run,
  output logic            ClearA_LoadB,
  output logic            Run_pulse,
  output logic            ClearA_LoadB_pulse,
  output logic [SW_W-1:0] SW_sync,
  output logic [SW_W-1:0] SW_held
);

  localparam int NumKeys = 2;

  localparam logic [1:0] REL        = 2'd0;
  localparam logic [1:0] PRESS_WAIT = 2'd1;
  localparam logic [1:0] PRS        = 2'd2;
  localparam logic [1:0] REL_WAIT   = 2'd3;

  localparam logic [15:0] CntLast = 16'(DEBOUNCE_CYCLES - 1);

  logic [1:0]         runSync_q, clbSync_q;
  logic [SW_W-1:0]    swMeta_q, swSync_q, swHeld_q;
  logic [NumKeys-1:0] keySync;

  logic [1:0]         state_q [NumKeys];
  logic [1:0]         state_d [NumKeys];
  logic [15:0]        cnt_q   [NumKeys];
  logic [15:0]        cnt_d   [NumKeys];
  logic [NumKeys-1:0] level_q, level_d;
  logic [NumKeys-1:0] pulse_q, pulse_d;

  // Key synchronisers idle at 1 so a reset never looks like a press.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      runSync_q <= 2'b11;
      clbSync_q <= 2'b11;
      swMeta_q  <= '0;
      swSync_q  <= '0;
    end else begin
      runSync_q <= {runSync_q[0], Run_n};
      clbSync_q <= {clbSync_q[0], ClearA_LoadB_n};
      swMeta_q  <= SW;
      swSync_q  <= swMeta_q;
    end
  end

  assign keySync = {clbSync_q[1], runSync_q[1]};

  // Index 0 is Run, index 1 is ClearA_LoadB; both keys use the same debounce rules.
  always_comb begin
    for (int k = 0; k < NumKeys; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      case (state_q[k])
        REL: begin
          if (!keySync[k]) begin
            state_d[k] = PRESS_WAIT;
            cnt_d[k]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (keySync[k]) begin
            state_d[k] = REL;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == CntLast) begin
            state_d[k] = PRS;
          end else begin
            cnt_d[k] = cnt_q[k] + 16'd1;
          end
        end
        PRS: begin
          if (keySync[k]) begin
            state_d[k] = REL_WAIT;
            cnt_d[k]   = '0;
          end
        end
        REL_WAIT: begin
          if (!keySync[k]) begin
            state_d[k] = PRS;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == CntLast) begin
            state_d[k] = REL;
          end else begin
            cnt_d[k] = cnt_q[k] + 16'd1;
          end
        end
        default: begin
          state_d[k] = REL;
          cnt_d[k]   = '0;
        end
      endcase
      level_d[k] = (state_d[k] == PRS) || (state_d[k] == REL_WAIT);
      pulse_d[k] = (state_q[k] == PRESS_WAIT) && (state_d[k] == PRS);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < NumKeys; k++) begin
        state_q[k] <= REL;
        cnt_q[k]   <= '0;
      end
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      for (int k = 0; k < NumKeys; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // Capture on the same edge that raises ClearA_LoadB_pulse.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      swHeld_q <= '0;
    end else if (pulse_d[1]) begin
      swHeld_q <= swSync_q;
    end
  end

  assign Run                = level_q[0];
  assign ClearA_LoadB       = level_q[1];
  assign Run_pulse          = pulse_q[0];
  assign ClearA_LoadB_pulse = pulse_q[1];
  assign SW_sync            = swSync_q;
  assign SW_held            = swHeld_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios with fixed expectations,
// plus randomized key/switch traffic compared against a run-length reference model.
module tb_input_conditioner;

  localparam int D = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Run_n;
  logic       ClearA_LoadB_n;
  logic [7:0] SW;
  logic       Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse;
  logic [7:0] SW_sync, SW_held;

  int testsRun    = 0;
  int testsFailed = 0;

  input_conditioner #(.DEBOUNCE_CYCLES(D), .SW_W(8)) dut (
    .Clk                (Clk),
    .Reset              (Reset),
    .Run_n              (Run_n),
    .ClearA_LoadB_n     (ClearA_LoadB_n),
    .SW                 (SW),
    .Run                (Run),
    .ClearA_LoadB       (ClearA_LoadB),
    .Run_pulse          (Run_pulse),
    .ClearA_LoadB_pulse (ClearA_LoadB_pulse),
    .SW_sync            (SW_sync),
    .SW_held            (SW_held)
  );

  always #5 Clk = ~Clk;

  // Reference model: keys arrive two edges late; a level flips after D+1
  // consecutive samples that disagree with it, and a flip to pressed is a pulse.
  logic       runQ[$];
  logic       clbQ[$];
  logic [7:0] swQ[$];
  logic       seen[2];
  logic       mLevel[2];
  logic       mPulse[2];
  int         runLen[2];
  logic [7:0] mSwSync, mSwHeld, oldSync;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      runQ = '{1'b1, 1'b1};
      clbQ = '{1'b1, 1'b1};
      swQ  = '{8'h00, 8'h00};
      for (int k = 0; k < 2; k++) begin
        mLevel[k] = 1'b0;
        mPulse[k] = 1'b0;
        runLen[k] = 0;
      end
      mSwSync = 8'h00;
      mSwHeld = 8'h00;
    end else begin
      seen[0] = runQ.pop_front();
      runQ.push_back(Run_n);
      seen[1] = clbQ.pop_front();
      clbQ.push_back(ClearA_LoadB_n);
      oldSync = swQ.pop_front();
      swQ.push_back(SW);
      mSwSync = swQ[0];
      for (int k = 0; k < 2; k++) begin
        mPulse[k] = 1'b0;
        if ((!seen[k]) != mLevel[k]) runLen[k]++;
        else runLen[k] = 0;
        if (runLen[k] == D + 1) begin
          mLevel[k] = !seen[k];
          mPulse[k] = !seen[k];
          runLen[k] = 0;
        end
      end
      if (mPulse[1]) mSwHeld = oldSync;
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    Run_n = 1'b1;
    ClearA_LoadB_n = 1'b1;
    repeat (n) tick();
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    Run_n = 1'b1;
    ClearA_LoadB_n = 1'b1;
    SW = 8'h00;
    repeat (2) tick();
    testsRun++;
    if ({Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse, SW_sync, SW_held} !== 12'h000) begin
      testsFailed++;
      $display("[TB] FAIL reset_initial: got %b %h %h expected 0000 00 00",
               {Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse}, SW_sync, SW_held);
    end
    Reset = 1'b1;
    Run_n = 1'b0;
    ClearA_LoadB_n = 1'b0;
    SW = 8'hFF;
    repeat (8) tick();
    testsRun++;
    if ({Run, ClearA_LoadB, SW_held} !== {2'b11, 8'hFF}) begin
      testsFailed++;
      $display("[TB] FAIL reset_preload: got levels %b held %h expected 11 ff",
               {Run, ClearA_LoadB}, SW_held);
    end
    #2;
    Reset = 1'b0;
    #1;
    testsRun++;
    if ({Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse, SW_sync, SW_held} !== 12'h000) begin
      testsFailed++;
      $display("[TB] FAIL reset_async: got %b %h %h expected 0000 00 00",
               {Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse}, SW_sync, SW_held);
    end
    Run_n = 1'b1;
    ClearA_LoadB_n = 1'b1;
    SW = 8'h00;
    repeat (2) tick();
    Reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      testsRun++;
      if ({Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse, SW_sync, SW_held} !== 12'h000) begin
        testsFailed++;
        $display("[TB] FAIL reset_quiet cycle %0d: got %b %h %h expected 0000 00 00", c,
                 {Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse}, SW_sync, SW_held);
      end
    end
  endtask

  task automatic test_clean_press;
    Run_n = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      testsRun++;
      if ({Run, Run_pulse, ClearA_LoadB} !== {(e >= 6), (e == 6), 1'b0}) begin
        testsFailed++;
        $display("[TB] FAIL clean_press E%0d: got Run/pulse/CLB %b expected %b", e,
                 {Run, Run_pulse, ClearA_LoadB}, {(e >= 6), (e == 6), 1'b0});
      end
    end
    idle(12);
    testsRun++;
    if (Run !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL clean_release: got Run %b expected 0", Run);
    end
  endtask

  task automatic test_bounce_rejection;
    logic pat[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int pulses = 0;
    for (int e = 0; e <= 14; e++) begin
      Run_n = (e < 7) ? pat[e] : 1'b0;
      tick();
      if (Run_pulse === 1'b1) pulses++;
      testsRun++;
      if ({Run, Run_pulse} !== {(e >= 9), (e == 9)}) begin
        testsFailed++;
        $display("[TB] FAIL bounce E%0d: got Run/pulse %b expected %b", e,
                 {Run, Run_pulse}, {(e >= 9), (e == 9)});
      end
    end
    testsRun++;
    if (pulses != 1) begin
      testsFailed++;
      $display("[TB] FAIL bounce_pulse_count: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_release_debounce;
    int pulses = 0;
    for (int e = 0; e <= 12; e++) begin
      Run_n = (e == 1) ? 1'b0 : 1'b1;
      tick();
      if (Run_pulse === 1'b1) pulses++;
      testsRun++;
      if (Run !== (e < 8)) begin
        testsFailed++;
        $display("[TB] FAIL release E%0d: got Run %b expected %b", e, Run, (e < 8));
      end
    end
    testsRun++;
    if (pulses != 0) begin
      testsFailed++;
      $display("[TB] FAIL release_pulse_count: got %0d expected 0", pulses);
    end
    idle(4);
  endtask

  task automatic test_switch_capture;
    SW = 8'hA5;
    repeat (3) tick();
    ClearA_LoadB_n = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      testsRun++;
      if ({ClearA_LoadB_pulse, SW_held} !== {(e == 6), ((e >= 6) ? 8'hA5 : 8'h00)}) begin
        testsFailed++;
        $display("[TB] FAIL capture E%0d: got pulse %b held %h expected %b %h", e,
                 ClearA_LoadB_pulse, SW_held, (e == 6), ((e >= 6) ? 8'hA5 : 8'h00));
      end
    end
    SW = 8'h3C;
    for (int e = 0; e < 6; e++) begin
      tick();
      testsRun++;
      if ({SW_sync, SW_held, ClearA_LoadB, ClearA_LoadB_pulse} !==
          {((e >= 1) ? 8'h3C : 8'hA5), 8'hA5, 2'b10}) begin
        testsFailed++;
        $display("[TB] FAIL hold E%0d: got sync %h held %h lvl/pulse %b expected %h a5 10", e,
                 SW_sync, SW_held, {ClearA_LoadB, ClearA_LoadB_pulse},
                 ((e >= 1) ? 8'h3C : 8'hA5));
      end
    end
    idle(12);
  endtask

  task automatic test_simultaneous_reset;
    Run_n = 1'b0;
    ClearA_LoadB_n = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      testsRun++;
      if ({Run_pulse, ClearA_LoadB_pulse} !== {2{(e == 6)}}) begin
        testsFailed++;
        $display("[TB] FAIL simultaneous E%0d: got pulses %b expected %b", e,
                 {Run_pulse, ClearA_LoadB_pulse}, {2{(e == 6)}});
      end
    end
    idle(12);
    Run_n = 1'b0;
    ClearA_LoadB_n = 1'b0;
    repeat (4) tick();
    Reset = 1'b0;
    #1;
    testsRun++;
    if ({Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL midwait_reset: got %b expected 0000",
               {Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse});
    end
    repeat (2) tick();
    Reset = 1'b1;
    for (int f = 0; f <= 7; f++) begin
      tick();
      testsRun++;
      if ({Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse} !== {{2{(f >= 6)}}, {2{(f == 6)}}}) begin
        testsFailed++;
        $display("[TB] FAIL redetect F%0d: got %b expected %b", f,
                 {Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse},
                 {{2{(f >= 6)}}, {2{(f == 6)}}});
      end
    end
    idle(12);
  endtask

  task automatic test_random;
    int hold[2] = '{0, 0};
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (hold[k] == 0) begin
          if (k == 0) Run_n = ~Run_n;
          else ClearA_LoadB_n = ~ClearA_LoadB_n;
          hold[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 12) : $urandom_range(1, 6);
        end
        hold[k]--;
      end
      if ($urandom_range(0, 3) == 0) SW = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        Reset = 1'b0;
        #1;
        testsRun++;
        if ({Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse, SW_sync, SW_held} !== 20'h0) begin
          testsFailed++;
          $display("[TB] FAIL random_reset cycle %0d: got %b %h %h expected zeros", c,
                   {Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse}, SW_sync, SW_held);
        end
        tick();
        Reset = 1'b1;
      end
      tick();
      testsRun++;
      if ({Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse} !==
          {mLevel[0], mLevel[1], mPulse[0], mPulse[1]}) begin
        testsFailed++;
        $display("[TB] FAIL random_keys cycle %0d: got %b expected %b", c,
                 {Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse},
                 {mLevel[0], mLevel[1], mPulse[0], mPulse[1]});
      end
      testsRun++;
      if ({SW_sync, SW_held} !== {mSwSync, mSwHeld}) begin
        testsFailed++;
        $display("[TB] FAIL random_switches cycle %0d: got sync %h held %h expected %h %h", c,
                 SW_sync, SW_held, mSwSync, mSwHeld);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b0;
    Run_n = 1'b1;
    ClearA_LoadB_n = 1'b1;
    SW = 8'h00;
    test_reset();
    test_clean_press();
    test_bounce_rejection();
    test_release_debounce();
    test_switch_capture();
    test_simultaneous_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
